// File: rtl/code_event_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | code_event_fifo_if : encoder-input / FIFO-output bundle              |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface code_event_fifo_if #(
   parameter int DEPTH = 4
);
   logic                   iEI;
   logic [2:0]             iCode;
   logic                   iEO;
   logic                   iClr;
   logic                   iReady;
   logic [2:0]             oData;
   logic                   oValid;
   logic [$clog2(DEPTH):0] oCount;
   logic                   oOvf;

   modport slave (
      input  iEI, iCode, iEO, iClr, iReady,
      output oData, oValid, oCount, oOvf
   );

   modport master (
      output iEI, iCode, iEO, iClr, iReady,
      input  oData, oValid, oCount, oOvf
   );
endinterface
`default_nettype wire

// File: rtl/code_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | code_event_fifo : debounces 8-3 encoder codes into a show-ahead FIFO |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module code_event_fifo #(
   parameter int STABLE = 3,
   parameter int DEPTH  = 4
) (
   input  wire logic         iClk,
   input  wire logic         iRst,
   code_event_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HELD = 2'd2
   } state_t;

   logic          ei_q;
   logic          eo_q;
   logic [2:0]    code_q;
   state_t        state_q;
   logic [2:0]    cand_q;
   logic [2:0]    held_q;
   logic [3:0]    cnt_q;
   logic [2:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   count_q;
   logic          ovf_q;

   logic active;
   logic stable_hit;
   logic push;
   logic pop;
   logic full;
   logic wr_en;

   assign active     = !ei_q && eo_q;
   // The next matching sample completes the run; >= keeps STABLE==1 from stalling in ARM
   assign stable_hit = ({1'b0, cnt_q} + 5'd1) >= 5'(STABLE);
   assign full       = (count_q == FULL_CNT);
   assign pop        = (count_q != '0) && bus.iReady;
   assign wr_en      = !iRst && !bus.iClr && push && (!full || pop);

   always_comb begin
      push = 1'b0;
      case (state_q)
         IDLE:    push = active && (STABLE == 1);
         ARM:     push = active && (code_q == cand_q) && stable_hit;
         default: push = 1'b0;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         ei_q   <= 1'b1;
         eo_q   <= 1'b0;
         code_q <= 3'd0;
      end else begin
         ei_q   <= bus.iEI;
         eo_q   <= bus.iEO;
         code_q <= bus.iCode;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         cand_q  <= 3'd0;
         held_q  <= 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (active) begin
                  cand_q <= code_q;
                  cnt_q  <= 4'd1;
                  if (STABLE == 1) begin
                     held_q  <= code_q;
                     state_q <= HELD;
                  end else begin
                     state_q <= ARM;
                  end
               end
            end
            ARM: begin
               if (!active) begin
                  state_q <= IDLE;
               end else if (code_q != cand_q) begin
                  cand_q <= code_q;
                  cnt_q  <= 4'd1;
               end else if (stable_hit) begin
                  held_q  <= cand_q;
                  state_q <= HELD;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            HELD: begin
               if (!active) begin
                  state_q <= IDLE;
               end else if (code_q != held_q) begin
                  cand_q  <= code_q;
                  cnt_q   <= 4'd1;
                  state_q <= ARM;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage is left unreset; the empty-state gating on oData hides stale entries
   always_ff @(posedge iClk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= code_q;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst || bus.iClr) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_en) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (push && full && !pop) begin
            ovf_q <= 1'b1;
         end
         if (wr_en && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (!wr_en && pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign bus.oValid = (count_q != '0);
   assign bus.oData  = bus.oValid ? mem_q[rptr_q] : 3'd0;
   assign bus.oCount = count_q;
   assign bus.oOvf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_code_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_code_event_fifo : directed + random check against run-length model|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_code_event_fifo;
   localparam int STABLE = 3;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   code_event_fifo_if #(.DEPTH(DEPTH)) bus ();

   code_event_fifo #(
      .STABLE (STABLE),
      .DEPTH  (DEPTH)
   ) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: a code is pushed on the edge where its run of identical
   // active registered samples reaches exactly STABLE.
   logic [2:0] mq [$];
   logic       m_ovf  = 1'b0;
   int         run    = 0;
   logic       m_act  = 1'b0;
   logic [2:0] m_code = 3'd0;
   bit         m_push;
   bit         m_pop;
   bit         m_na;
   bit         cmp_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         run    = 0;
         m_act  = 1'b0;
         m_code = 3'd0;
      end else begin
         m_push = (run == STABLE);
         if (bus.iClr) begin
            mq.delete();
            m_ovf = 1'b0;
         end else begin
            m_pop = (mq.size() > 0) && bus.iReady;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
               if (mq.size() < DEPTH) mq.push_back(m_code);
               else                   m_ovf = 1'b1;
            end
         end
         m_na = !bus.iEI && bus.iEO;
         if (m_na) run = (m_act && bus.iCode == m_code) ? ((run > STABLE) ? run : run + 1) : 1;
         else      run = 0;
         m_act  = m_na;
         m_code = bus.iCode;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model oValid", 32'(bus.oValid), 32'(mq.size() > 0));
         chk("model oData",  32'(bus.oData),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
         chk("model oCount", 32'(bus.oCount), 32'(mq.size()));
         chk("model oOvf",   32'(bus.oOvf),   32'(m_ovf));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic inactive();
      bus.iEI = 1'b1;
      bus.iEO = 1'b0;
   endtask

   task automatic do_reset();
      inactive();
      bus.iReady = 1'b0;
      bus.iClr   = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic hold_code(input int c, input int n);
      bus.iEI   = 1'b0;
      bus.iEO   = 1'b1;
      bus.iCode = 3'(c);
      repeat (n) step();
   endtask

   initial begin
      bus.iEI = 1'b1; bus.iEO = 1'b0; bus.iCode = 3'd0;
      bus.iClr = 1'b0; bus.iReady = 1'b0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset oValid", 32'(bus.oValid), 32'd0);
      chk("reset oData",  32'(bus.oData),  32'd0);
      chk("reset oCount", 32'(bus.oCount), 32'd0);
      chk("reset oOvf",   32'(bus.oOvf),   32'd0);

      // Latency of a steady code from an empty FIFO
      do_reset();
      hold_code(5, 3);
      chk("latency early", 32'(bus.oValid), 32'd0);
      step();
      chk("latency oValid", 32'(bus.oValid), 32'd1);
      chk("latency oData",  32'(bus.oData),  32'd5);
      chk("latency oCount", 32'(bus.oCount), 32'd1);
      repeat (6) step();
      chk("held no repush", 32'(bus.oCount), 32'd1);

      // Short-lived code 2 is rejected
      do_reset();
      hold_code(2, 2);
      hold_code(6, 3);
      chk("glitch early", 32'(bus.oCount), 32'd0);
      step();
      chk("glitch oCount", 32'(bus.oCount), 32'd1);
      chk("glitch oData",  32'(bus.oData),  32'd6);

      // Encoder disabled or idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         bus.iEI = 1'b1; bus.iEO = 1'($urandom_range(0, 1));
         bus.iCode = 3'($urandom_range(0, 7));
         step();
      end
      chk("disable EI", 32'(bus.oCount), 32'd0);
      bus.iEI = 1'b0; bus.iEO = 1'b0; bus.iCode = 3'd3;
      repeat (10) step();
      chk("disable EO", 32'(bus.oCount), 32'd0);

      // Overflow, ordered drain, sticky flag, clear
      do_reset();
      for (int c = 1; c <= 5; c++) hold_code(c, 5);
      inactive();
      step();
      chk("ovf oCount", 32'(bus.oCount), 32'd4);
      chk("ovf oOvf",   32'(bus.oOvf),   32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("ovf pop data", 32'(bus.oData), 32'(k + 1));
         bus.iReady = 1'b1;
         step();
         bus.iReady = 1'b0;
      end
      chk("ovf drained", 32'(bus.oCount), 32'd0);
      chk("ovf sticky",  32'(bus.oOvf),   32'd1);
      bus.iClr = 1'b1;
      step();
      bus.iClr = 1'b0;
      chk("clr oCount", 32'(bus.oCount), 32'd0);
      chk("clr oOvf",   32'(bus.oOvf),   32'd0);

      // Push and pop together while full
      do_reset();
      for (int c = 1; c <= 4; c++) hold_code(c, 5);
      hold_code(6, 3);
      bus.iReady = 1'b1;
      step();
      bus.iReady = 1'b0;
      inactive();
      chk("full pp oCount", 32'(bus.oCount), 32'd4);
      chk("full pp oOvf",   32'(bus.oOvf),   32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("full pp order", 32'(bus.oData), (k == 3) ? 32'd6 : 32'(k + 2));
         bus.iReady = 1'b1;
         step();
         bus.iReady = 1'b0;
      end

      // Reset while arming
      do_reset();
      hold_code(7, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst arm oValid", 32'(bus.oValid), 32'd0);
      repeat (3) step();
      chk("rst arm early", 32'(bus.oCount), 32'd0);
      step();
      chk("rst arm oCount", 32'(bus.oCount), 32'd1);
      chk("rst arm oData",  32'(bus.oData),  32'd7);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) bus.iCode = 3'($urandom_range(0, 7));
         bus.iEI    = ($urandom_range(0, 15) == 0);
         bus.iEO    = ($urandom_range(0, 15) != 0);
         bus.iReady = ($urandom_range(0, 3) == 0);
         bus.iClr   = ($urandom_range(0, 199) == 0);
         rst        = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      bus.iClr = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/code_event_fifo.md
CODE_EVENT_FIFO -- requirements
Module: code_event_fifo

Interface
REQ-001 SHALL have parameter STABLE, default 3: consecutive sampled cycles a code must hold before it is accepted; legal range 1..15.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-003 SHALL have port iClk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port iRst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port iEI, input, 1: active-low enable, the same signal driven to the upstream 8-3 priority encoder.
REQ-006 SHALL have port iCode, input, 3: encoder output code, the index of the highest-priority asserted request line.
REQ-007 SHALL have port iEO, input, 1: encoder enable-out; 0 means the encoder is enabled and no request line is asserted.
REQ-008 SHALL have port iClr, input, 1: synchronous clear of FIFO contents and overflow flag.
REQ-009 SHALL have port iReady, input, 1: consumer ready.
REQ-010 SHALL have port oData, output, 3: code at the FIFO head.
REQ-011 SHALL have port oValid, output, 1: FIFO non-empty.
REQ-012 SHALL have port oCount, output, clog2(DEPTH)+1: FIFO occupancy, 3 bits at default.
REQ-013 SHALL have port oOvf, output, 1: sticky overflow flag.

Function
REQ-014 SHALL register iEI, iEO and iCode once per cycle; all further logic SHALL use only the registered copies.
REQ-015 SHALL define "active" as registered iEI==0 and registered iEO==1.
REQ-016 SHALL implement FSM states IDLE, ARM and HELD, with a candidate register, a held register and a stability counter.
REQ-017 IDLE: when active, SHALL load the candidate with the code, set the counter to 1 and go to ARM; if STABLE==1 it SHALL instead push the code and go to HELD.
REQ-018 ARM: when not active, SHALL go to IDLE with no push.
REQ-019 ARM: when the code differs from the candidate, SHALL reload the candidate and set the counter to 1.
REQ-020 ARM: when the code matches and the counter equals STABLE-1, SHALL push the candidate, copy it to held and go to HELD; otherwise it SHALL increment the counter.
REQ-021 HELD: when not active, SHALL go to IDLE.
REQ-022 HELD: when the code differs from held, SHALL go to ARM with candidate=code and counter=1.
REQ-023 HELD: an unchanged code SHALL cause no further pushes.
REQ-024 SHALL make the FIFO show-ahead: oData equals the head entry whenever oValid=1, and oData=0 when the FIFO is empty.
REQ-025 SHALL pop when oValid && iReady, and SHALL ignore iReady while the FIFO is empty.
REQ-026 Latency: with the FIFO empty and a steady active code first sampled at edge 0, the FIFO SHALL be written at edge STABLE and oValid SHALL be high right after that edge.
REQ-027 On push and pop in the same cycle with the FIFO non-empty, SHALL perform both and leave oCount unchanged; this applies even when the FIFO is full.
REQ-028 On push while full without a pop, SHALL drop the new code, leave the contents unchanged and set oOvf.
REQ-029 SHALL hold oOvf at 1 until iRst or iClr.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 iClr SHALL empty the FIFO, clear oOvf and discard any push or pop in the same cycle; FSM state and input registers SHALL be unaffected.
REQ-032 Priority SHALL be iRst > iClr > push/pop.

Reset
REQ-033 On iRst=1 at an edge: state=IDLE, counter=0, candidate=held=0, registered inputs=inactive (iEI=1, iEO=0), pointers=0, oValid=0, oData=0, oCount=0, oOvf=0.
REQ-034 Reset asserted mid-ARM or mid-HELD SHALL abort without pushing; a code still active after release SHALL restart from IDLE.

Verification
REQ-035 Latency: iEI=0, iEO=1, iCode=5 held from edge 0, iReady=0 -> oValid=1 and oData=5 after edge 3, oCount=1; no second push while held.
REQ-036 Glitch reject: iCode 2 for 2 cycles then 6 held -> only 6 pushed, at the 3rd edge after 6 is sampled; code 2 never appears.
REQ-037 Disable: iEI=1 with any iCode/iEO -> no push; iEO=0 while iEI=0 -> no push.
REQ-038 Overflow: five distinct stable codes 1,2,3,4,5 with iReady=0 -> oCount=4, oOvf=1, pops return 1,2,3,4; then iClr -> oCount=0, oOvf=0.
REQ-039 Full push+pop: FIFO full, iReady=1 on the same cycle as a new push -> oCount stays 4, oOvf=0, order preserved.
REQ-040 Reset mid-ARM: code 7 active 2 cycles, iRst pulse, code held -> FIFO empty after reset, 7 pushed 3 edges after reset release plus sampling.
